// File: rtl/udp_tx_pkg.sv
// ---------------------------------------------------------------------------
// udp_tx_pkg
// Shared definitions for the UDP transmit scheduler: FSM state encoding,
// default timing/length limits and the payload-length acceptance check.
// ---------------------------------------------------------------------------
package udp_tx_pkg;

    // Idle clocks between frames: 96 bit times at 100M MII = 24 nibbles.
    localparam int IFG_NIBBLES_DEF   = 24;
    // Max clocks from tx_go until the transmitter raises mii_tx_en.
    localparam int START_TIMEOUT_DEF = 255;
    // Largest UDP payload that fits a standard Ethernet frame.
    localparam int MAX_LEN_DEF       = 1472;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_EN = 3'd3,
        ST_SEND    = 3'd4,
        ST_IFG     = 3'd5
    } tx_state_e;

    // Unsigned 16-bit check: zero-length and oversize payloads are rejected.
    function automatic logic len_ok(input logic [15:0] len,
                                    input logic [15:0] max_len);
        return (len != 16'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter (purely combinational).
//   req   [1:0] in  : request per source
//   last        in  : index of the source granted most recently
//   grant [1:0] out : one-hot grant, 2'b00 when nobody requests
// On a tie the source that was not granted last wins.
// ---------------------------------------------------------------------------
module rr_arb2
    import udp_tx_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || last)) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// ---------------------------------------------------------------------------
// udp_tx_scheduler
// Arbitrates two payload sources onto one external udp_protocol transmitter.
// Latches the winner's length/ports, fires tx_go, watches mii_tx_en for the
// start (with timeout) and end of the frame, then enforces the inter-frame gap.
//
// Ports
//   mii_tx_clk, rst_n (async, active-low)
//   req0/1, len0/1, sport0/1, dport0/1 : per-source frame request + header
//   rd0/1 out, da0/1 in                : per-source payload FIFO nibble port
//   gnt/done/err [1:0] out             : one-hot grant, completion, reject/abort
//   tx_go, data_len, sour_port, dest_port, udp_ck_sum, fifo_da : to transmitter
//   fifo_rq in, mii_tx_en in           : from transmitter / MII
//   busy out                           : high whenever not IDLE
//   state_dbg out                      : current FSM state
//
// Handshake: a source raises req with len/ports valid and holds them until
// it sees its done or err bit; it must drop req in that same pulse cycle.
// A req still high when the scheduler re-enters IDLE is a new frame; req is
// not looked at during the gap.
// ---------------------------------------------------------------------------
module udp_tx_scheduler
    import udp_tx_pkg::*;
#(
    parameter int IFG_NIBBLES   = IFG_NIBBLES_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF,
    parameter int MAX_LEN       = MAX_LEN_DEF
) (
    input  logic        mii_tx_clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] len0,
    input  logic [15:0] len1,
    input  logic [15:0] sport0,
    input  logic [15:0] sport1,
    input  logic [15:0] dport0,
    input  logic [15:0] dport1,
    output logic        rd0,
    output logic        rd1,
    input  logic [3:0]  da0,
    input  logic [3:0]  da1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        tx_go,
    output logic [15:0] data_len,
    output logic [15:0] sour_port,
    output logic [15:0] dest_port,
    output logic [15:0] udp_ck_sum,
    output logic [3:0]  fifo_da,
    input  logic        fifo_rq,
    input  logic        mii_tx_en,
    output logic        busy,
    output tx_state_e   state_dbg
);

    localparam logic [7:0]  IFG_LAST = 8'(IFG_NIBBLES - 1);
    localparam logic [7:0]  TMO_END  = 8'(START_TIMEOUT);
    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

    tx_state_e   state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic        last_q, last_d;
    logic        en_prev_q, en_prev_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  ifg_q, ifg_d;
    logic [15:0] data_len_q, data_len_d;
    logic [15:0] sour_port_q, sour_port_d;
    logic [15:0] dest_port_q, dest_port_d;

    logic [1:0]  arb_grant;
    logic [15:0] sel_len, sel_sport, sel_dport;
    logic [7:0]  tmo_inc;

    rr_arb2 u_arb (
        .req   ({req1, req0}),
        .last  (last_q),
        .grant (arb_grant)
    );

    // gnt_q is one-hot whenever LOAD is active, so a 2:1 mux suffices.
    assign sel_len   = gnt_q[1] ? len1   : len0;
    assign sel_sport = gnt_q[1] ? sport1 : sport0;
    assign sel_dport = gnt_q[1] ? dport1 : dport0;
    assign tmo_inc   = tmo_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = 2'b00;
        err_d       = 2'b00;
        last_d      = last_q;
        en_prev_d   = mii_tx_en;
        tmo_d       = tmo_q;
        ifg_d       = ifg_q;
        data_len_d  = data_len_q;
        sour_port_d = sour_port_q;
        dest_port_d = dest_port_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_grant != 2'b00) begin
                    gnt_d   = arb_grant;
                    last_d  = arb_grant[1];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_len_d  = sel_len;
                sour_port_d = sel_sport;
                dest_port_d = sel_dport;
                if (!len_ok(sel_len, MAX_LEN16)) begin
                    err_d   = gnt_q;
                    gnt_d   = 2'b00;
                    ifg_d   = 8'd0;
                    state_d = ST_IFG;
                end else begin
                    tmo_d   = 8'd0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // The timeout counts from the tx_go clock itself.
                tmo_d   = tmo_inc;
                state_d = ST_WAIT_EN;
            end
            ST_WAIT_EN: begin
                if (mii_tx_en) begin
                    state_d = ST_SEND;
                end else if (tmo_inc == TMO_END) begin
                    err_d   = gnt_q;
                    gnt_d   = 2'b00;
                    ifg_d   = 8'd0;
                    state_d = ST_IFG;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_SEND: begin
                if (en_prev_q && !mii_tx_en) begin
                    done_d  = gnt_q;
                    gnt_d   = 2'b00;
                    ifg_d   = 8'd0;
                    state_d = ST_IFG;
                end
            end
            ST_IFG: begin
                if (ifg_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_d = ifg_q + 8'd1;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            last_q      <= 1'b1;
            en_prev_q   <= 1'b0;
            tmo_q       <= 8'd0;
            ifg_q       <= 8'd0;
            data_len_q  <= 16'd0;
            sour_port_q <= 16'd0;
            dest_port_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_q      <= last_d;
            en_prev_q   <= en_prev_d;
            tmo_q       <= tmo_d;
            ifg_q       <= ifg_d;
            data_len_q  <= data_len_d;
            sour_port_q <= sour_port_d;
            dest_port_q <= dest_port_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign tx_go      = (state_q == ST_START);
    assign busy       = (state_q != ST_IDLE);
    assign state_dbg  = state_q;
    assign data_len   = data_len_q;
    assign sour_port  = sour_port_q;
    assign dest_port  = dest_port_q;
    assign udp_ck_sum = 16'h0000;
    assign rd0        = fifo_rq & gnt_q[0];
    assign rd1        = fifo_rq & gnt_q[1];
    assign fifo_da    = gnt_q[0] ? da0 : (gnt_q[1] ? da1 : 4'h0);

endmodule

// File: tb/tb_udp_tx_scheduler.sv
module tb_udp_tx_scheduler;
    import udp_tx_pkg::*;

    // ---------------- clock / reset ----------------
    logic mii_tx_clk = 1'b0;
    always #5 mii_tx_clk = ~mii_tx_clk;

    logic        rst_n;
    logic        req0, req1;
    logic [15:0] len0, len1, sport0, sport1, dport0, dport1;
    logic        rd0, rd1;
    logic [3:0]  da0, da1;
    logic [1:0]  gnt, done, err;
    logic        tx_go;
    logic [15:0] data_len, sour_port, dest_port, udp_ck_sum;
    logic [3:0]  fifo_da;
    logic        fifo_rq, mii_tx_en, busy;
    tx_state_e   state_dbg;

    udp_tx_scheduler dut (
        .mii_tx_clk (mii_tx_clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .len0       (len0),
        .len1       (len1),
        .sport0     (sport0),
        .sport1     (sport1),
        .dport0     (dport0),
        .dport1     (dport1),
        .rd0        (rd0),
        .rd1        (rd1),
        .da0        (da0),
        .da1        (da1),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .tx_go      (tx_go),
        .data_len   (data_len),
        .sour_port  (sour_port),
        .dest_port  (dest_port),
        .udp_ck_sum (udp_ck_sum),
        .fifo_da    (fifo_da),
        .fifo_rq    (fifo_rq),
        .mii_tx_en  (mii_tx_en),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    int tests = 0;
    int fails = 0;
    int go_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge mii_tx_clk) begin
        if (tx_go) go_cnt++;
        if (done != 2'b00) done_cnt++;
        if (err != 2'b00) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge mii_tx_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs;
        req0 = 1'b0; req1 = 1'b0;
        len0 = 16'd0; len1 = 16'd0;
        sport0 = 16'd0; sport1 = 16'd0;
        dport0 = 16'd0; dport1 = 16'd0;
        da0 = 4'h0; da1 = 4'h0;
        fifo_rq = 1'b0; mii_tx_en = 1'b0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        go_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic wait_go(input string tag);
        int n = 0;
        while (tx_go !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(tx_go), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    // One full frame for the expected winner; keep=1 re-raises its request
    // during the gap so both sources contend again at the next IDLE.
    task automatic do_frame(input logic [1:0] exp_g, input bit keep, input string tag);
        wait_go({tag, "_go"});
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
        tick();
        mii_tx_en = 1'b1;
        repeat (5) tick();
        mii_tx_en = 1'b0;
        tick();
        chk({tag, "_done"}, 32'(done), 32'(exp_g));
        if (exp_g[0]) req0 = 1'b0;
        if (exp_g[1]) req1 = 1'b0;
        if (keep) begin
            tick();
            if (exp_g[0]) req0 = 1'b1;
            if (exp_g[1]) req1 = 1'b1;
        end else begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        wait_idle({tag, "_idle"});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        logic       e_rq;
        logic [3:0] e_da;

        // Reset values
        clear_inputs();
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txgo", 32'(tx_go), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_len", 32'(data_len), 32'd0);
        chk("rst_fifo_da", 32'(fifo_da), 32'd0);
        chk("rst_rd", 32'({rd1, rd0}), 32'd0);

        // Single frame from source 0
        apply_reset();
        len0 = 16'd18; sport0 = 16'h1234; dport0 = 16'h0044; req0 = 1'b1;
        tick();
        chk("a_load_state", 32'(state_dbg), 32'(ST_LOAD));
        chk("a_load_gnt", 32'(gnt), 32'h1);
        chk("a_load_busy", 32'(busy), 32'd1);
        tick();
        chk("a_txgo", 32'(tx_go), 32'd1);
        chk("a_len", 32'(data_len), 32'd18);
        chk("a_sport", 32'(sour_port), 32'h1234);
        chk("a_dport", 32'(dest_port), 32'h0044);
        chk("a_cksum", 32'(udp_ck_sum), 32'h0);
        tick();
        chk("a_txgo_drop", 32'(tx_go), 32'd0);
        tick(); tick();
        mii_tx_en = 1'b1;
        tick();
        chk("a_send_state", 32'(state_dbg), 32'(ST_SEND));
        fifo_rq = 1'b1; da0 = 4'hA; da1 = 4'h5;
        #1;
        chk("a_rd", 32'({rd1, rd0}), 32'h1);
        chk("a_fifo_da", 32'(fifo_da), 32'hA);
        fifo_rq = 1'b0;
        repeat (119) tick();
        chk("a_no_early_done", 32'(done_cnt), 32'd0);
        mii_tx_en = 1'b0;
        tick();
        chk("a_done", 32'(done), 32'h1);
        chk("a_gnt_clr", 32'(gnt), 32'h0);
        chk("a_ifg_state", 32'(state_dbg), 32'(ST_IFG));
        chk("a_len_held", 32'(data_len), 32'd18);
        req0 = 1'b0;
        repeat (23) tick();
        chk("a_ifg_busy", 32'(busy), 32'd1);
        tick();
        chk("a_ifg_end", 32'(busy), 32'd0);
        chk("a_go_cnt", 32'(go_cnt), 32'd1);
        chk("a_done_cnt", 32'(done_cnt), 32'd1);

        // Round-robin alternation with both sources requesting
        apply_reset();
        len0 = 16'd20; len1 = 16'd30;
        req0 = 1'b1; req1 = 1'b1;
        do_frame(2'b01, 1'b1, "rr0");
        do_frame(2'b10, 1'b1, "rr1");
        do_frame(2'b01, 1'b1, "rr2");
        do_frame(2'b10, 1'b0, "rr3");
        chk("rr_go_cnt", 32'(go_cnt), 32'd4);

        // Length rejection: zero, MAX_LEN+1, then MAX_LEN accepted
        apply_reset();
        len1 = 16'd0; req1 = 1'b1;
        tick();
        chk("c0_gnt", 32'(gnt), 32'h2);
        tick();
        chk("c0_err", 32'(err), 32'h2);
        chk("c0_ifg", 32'(state_dbg), 32'(ST_IFG));
        chk("c0_gnt_clr", 32'(gnt), 32'h0);
        req1 = 1'b0;
        wait_idle("c0_idle");
        len1 = 16'd1473; req1 = 1'b1;
        tick(); tick();
        chk("c1_err", 32'(err), 32'h2);
        chk("c1_ifg", 32'(state_dbg), 32'(ST_IFG));
        req1 = 1'b0;
        wait_idle("c1_idle");
        chk("c_no_go", 32'(go_cnt), 32'd0);
        chk("c_err_cnt", 32'(err_cnt), 32'd2);
        len1 = 16'd1472; req1 = 1'b1;
        do_frame(2'b10, 1'b0, "cmax");
        chk("cmax_len", 32'(data_len), 32'd1472);

        // Start timeout: mii_tx_en never rises
        apply_reset();
        len0 = 16'd64; req0 = 1'b1;
        wait_go("d_go");
        n = 0;
        while (err === 2'b00 && n < 400) begin
            tick();
            n++;
        end
        chk("d_tmo_clocks", 32'(n), 32'd255);
        chk("d_err", 32'(err), 32'h1);
        chk("d_ifg", 32'(state_dbg), 32'(ST_IFG));
        req0 = 1'b0;
        wait_idle("d_idle");
        chk("d_no_done", 32'(done_cnt), 32'd0);

        // Payload path follows the granted source 1
        apply_reset();
        len1 = 16'd40; req1 = 1'b1;
        wait_go("e_go");
        chk("e_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 6; i++) begin
            e_rq = (i % 2) == 1;
            e_da = 4'(3 * i + 2);
            fifo_rq = e_rq;
            da1 = e_da;
            da0 = 4'hF;
            #1;
            chk("e_rd1", 32'(rd1), 32'(e_rq));
            chk("e_rd0", 32'(rd0), 32'd0);
            chk("e_fifo_da", 32'(fifo_da), 32'(e_da));
            tick();
        end
        fifo_rq = 1'b0;
        mii_tx_en = 1'b1;
        repeat (3) tick();
        mii_tx_en = 1'b0;
        tick();
        chk("e_done", 32'(done), 32'h2);
        req1 = 1'b0;
        wait_idle("e_idle");

        // Reset in the middle of SEND
        apply_reset();
        len0 = 16'd50; req0 = 1'b1;
        wait_go("f_go");
        tick();
        mii_tx_en = 1'b1;
        tick(); tick();
        chk("f_send", 32'(state_dbg), 32'(ST_SEND));
        rst_n = 1'b0;
        req0 = 1'b0;
        mii_tx_en = 1'b0;
        #1;
        chk("f_async_busy", 32'(busy), 32'd0);
        tick();
        chk("f_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("f_outs", 32'({gnt, done, err, tx_go, rd1, rd0, busy}), 32'd0);
        chk("f_len", 32'(data_len), 32'd0);
        chk("f_fifo_da", 32'(fifo_da), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("f_no_done", 32'(done_cnt), 32'd0);
        len0 = 16'd22; req0 = 1'b1;
        do_frame(2'b01, 1'b0, "f_post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
